systolic_feeder_2x2: RTL and testbench
======================================

SYSTOLIC_FEEDER_2X2 -- requirements
Module: systolic_feeder_2x2

Interface
REQ-001 SHALL have parameter DW, default 2: operand element width in bits.
REQ-002 SHALL have parameter TIMEOUT, default 15: maximum WAIT cycles before the error abort.
REQ-003 SHALL have port clk  input  1: single clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1: reset; synchronous, active-low.
REQ-005 SHALL have port start  input  1: request to launch one 2x2 multiply.
REQ-006 SHALL have port a_mat  input  4*DW: matrix A as {a11,a10,a01,a00}, with a00 in the LSBs.
REQ-007 SHALL have port b_mat  input  4*DW: matrix B as {b11,b10,b01,b00}, with b00 in the LSBs.
REQ-008 SHALL have port arr_done  input  1: completion pulse from the downstream array.
REQ-009 SHALL have port ready  output  1: high only in IDLE.
REQ-010 SHALL have ports row_in_row0, row_in_row1, col_in_col0, col_in_col1  output  DW each: skewed operand streams to the array.
REQ-011 SHALL have port load_in  output  1: high on every feed beat.
REQ-012 SHALL have port feed_done  output  1: one-cycle pulse when the array completes.
REQ-013 SHALL have port timeout_err  output  1: sticky abort flag.

Function
REQ-014 SHALL implement states IDLE, FEED, WAIT and FLUSH, all registered.
REQ-015 SHALL, in IDLE with start=1, latch a_mat and b_mat, clear the beat counter, and go to FEED; in IDLE with start=0, remain in IDLE.
REQ-016 SHALL ignore start in all states other than IDLE; the latched operands SHALL NOT change outside IDLE.
REQ-017 SHALL run FEED for exactly 3 cycles (beats 0, 1, 2), with load_in=1 on each beat.
REQ-018 SHALL drive beat 0 as: row0=a00, row1=0, col0=b00, col1=0.
REQ-019 SHALL drive beat 1 as: row0=a01, row1=a10, col0=b10, col1=b01.
REQ-020 SHALL drive beat 2 as: row0=0, row1=a11, col0=0, col1=b11.
REQ-021 SHALL register all stream outputs and load_in; the first beat appears the cycle after start is sampled.
REQ-022 SHALL hold all streams at 0 and load_in at 0 outside FEED.
REQ-023 SHALL go from beat 2 to WAIT and clear the WAIT counter.
REQ-024 SHALL, in WAIT with arr_done=1, pulse feed_done for one cycle and return to IDLE on the next cycle.
REQ-025 SHALL, in WAIT, increment the WAIT counter each cycle with arr_done=0; when the counter reaches TIMEOUT, set timeout_err, go to FLUSH, and NOT pulse feed_done.
REQ-026 SHALL have the WAIT counter at least clog2(TIMEOUT+1) bits wide, with no wrap.
REQ-027 SHALL, in FLUSH, drive zeros for 1 cycle and then return to IDLE.
REQ-028 SHALL clear timeout_err only on the next accepted start or on reset.
REQ-029 SHALL ignore arr_done in IDLE, FEED and FLUSH: no pulse, no state effect.
REQ-030 SHALL, when arr_done arrives on the same cycle the WAIT counter reaches TIMEOUT, let arr_done win: feed_done pulses and timeout_err stays 0.
REQ-031 SHALL make the start-to-first-beat latency 1 cycle, and the minimum start-to-feed_done latency 5 cycles (with arr_done on the first WAIT cycle).
REQ-032 SHALL allow back-to-back operation: start may be accepted on the cycle ready returns high.

Reset
REQ-033 SHALL, with rst=0 at a clock edge, go to IDLE and set: ready=1, load_in=0, all streams 0, feed_done=0, timeout_err=0, counters 0, operand latches 0.
REQ-034 SHALL, when reset is asserted mid-FEED or mid-WAIT, abort immediately with no feed_done and no timeout_err.
REQ-035 SHALL make reset take priority over start and arr_done in the same cycle.

Verification
REQ-036 SHALL cover a basic multiply: A=[1,2;3,0], B=[2,1;0,3], start 1 cycle -> beats (1,0,2,0), (2,3,0,1), (0,0,0,3), load_in high 3 cycles, arr_done in cycle 2 of WAIT -> single feed_done, ready=1 the next cycle.
REQ-037 SHALL cover a timeout: no arr_done -> after 15 WAIT cycles timeout_err=1, 1 FLUSH cycle, then ready=1 and no feed_done; a new start clears timeout_err.
REQ-038 SHALL cover start held high through a whole transaction with a_mat changing mid-FEED -> stream values from the originally latched operands only, and a second transaction starts immediately after return to IDLE.
REQ-039 SHALL cover reset (rst=0) on FEED beat 1 -> next cycle all outputs at their reset values and ready=1; a later arr_done produces no pulse.
REQ-040 SHALL cover a stray arr_done in IDLE and during FEED -> no feed_done and no state change; arr_done coinciding with the TIMEOUT cycle -> feed_done=1 and timeout_err=0.
REQ-041 SHALL cover all-max operands (all elements 3 at DW=2) -> streams carry 3s exactly per REQ-018 to REQ-020 and zeros elsewhere.

Source files
------------

// File: rtl/systolic_feeder_2x2.sv
// 2x2 systolic-array operand feeder.
// Latches A and B on an accepted start, streams them into the array as three skewed
// beats, then waits for the array's completion pulse or aborts after TIMEOUT idle cycles.
module systolic_feeder_2x2 #(
  parameter int unsigned DW      = 2,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [4*DW-1:0] a_mat,
  input  logic [4*DW-1:0] b_mat,
  input  logic          arr_done,
  output logic          ready,
  output logic [DW-1:0] row_in_row0,
  output logic [DW-1:0] row_in_row1,
  output logic [DW-1:0] col_in_col0,
  output logic [DW-1:0] col_in_col1,
  output logic          load_in,
  output logic          feed_done,
  output logic          timeout_err
);

  // Wide enough to hold TIMEOUT itself; never narrower than one bit.
  localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW:0] TimeoutVal = TIMEOUT[CW:0];

  typedef enum logic [1:0] {
    StIdle,
    StFeed,
    StWait,
    StFlush
  } state_e;

  state_e          r_state, w_state_d;
  logic [1:0]      r_beat, w_beat_d;
  logic [CW-1:0]   r_wcnt, w_wcnt_d;
  logic [CW:0]     w_wcnt_next;
  logic [4*DW-1:0] r_a, r_b, w_a_d, w_b_d;

  logic [DW-1:0]   r_row0, r_row1, r_col0, r_col1;
  logic [DW-1:0]   w_row0_d, w_row1_d, w_col0_d, w_col1_d;
  logic            r_load, w_load_d;
  logic            r_feed_done, w_feed_done_d;
  logic            r_timeout_err, w_timeout_err_d;

  logic            w_start_acc;
  logic            w_wait_live;
  logic            w_hit_timeout;

  assign w_start_acc   = (r_state == StIdle) && start;
  // The cycle after arr_done is sampled carries the feed_done pulse; WAIT then exits.
  assign w_wait_live   = (r_state == StWait) && !r_feed_done;
  assign w_wcnt_next   = {1'b0, r_wcnt} + {{CW{1'b0}}, 1'b1};
  // arr_done outranks the timeout when both land on the same cycle.
  assign w_hit_timeout = w_wait_live && !arr_done && (w_wcnt_next == TimeoutVal);

  // State, beat/wait counters and operand latches.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= StIdle;
      r_beat  <= '0;
      r_wcnt  <= '0;
      r_a     <= '0;
      r_b     <= '0;
    end else begin
      r_state <= w_state_d;
      r_beat  <= w_beat_d;
      r_wcnt  <= w_wcnt_d;
      r_a     <= w_a_d;
      r_b     <= w_b_d;
    end
  end

  // Next-state, counter and latch update.
  always_comb begin
    w_state_d = r_state;
    w_beat_d  = r_beat;
    w_wcnt_d  = r_wcnt;
    w_a_d     = r_a;
    w_b_d     = r_b;
    unique case (r_state)
      StIdle: begin
        if (start) begin
          w_state_d = StFeed;
          w_beat_d  = 2'd0;
          w_a_d     = a_mat;
          w_b_d     = b_mat;
        end
      end
      StFeed: begin
        if (r_beat == 2'd2) begin
          w_state_d = StWait;
          w_wcnt_d  = '0;
        end else begin
          w_beat_d = r_beat + 2'd1;
        end
      end
      StWait: begin
        if (r_feed_done) begin
          w_state_d = StIdle;
        end else if (arr_done) begin
          w_state_d = StWait;
        end else if (w_hit_timeout) begin
          w_state_d = StFlush;
          w_wcnt_d  = w_wcnt_next[CW-1:0];
        end else begin
          w_wcnt_d = w_wcnt_next[CW-1:0];
        end
      end
      StFlush: begin
        w_state_d = StIdle;
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  // Next values of the registered outputs, aligned with the next state so beat 0
  // is visible the cycle after start is sampled.
  always_comb begin
    w_row0_d = '0;
    w_row1_d = '0;
    w_col0_d = '0;
    w_col1_d = '0;
    w_load_d = 1'b0;
    if (w_state_d == StFeed) begin
      w_load_d = 1'b1;
      unique case (w_beat_d)
        2'd0: begin
          w_row0_d = w_a_d[DW-1:0];
          w_col0_d = w_b_d[DW-1:0];
        end
        2'd1: begin
          w_row0_d = w_a_d[2*DW-1:DW];
          w_row1_d = w_a_d[3*DW-1:2*DW];
          w_col0_d = w_b_d[3*DW-1:2*DW];
          w_col1_d = w_b_d[2*DW-1:DW];
        end
        2'd2: begin
          w_row1_d = w_a_d[4*DW-1:3*DW];
          w_col1_d = w_b_d[4*DW-1:3*DW];
        end
        default: begin
          w_load_d = 1'b0;
        end
      endcase
    end
    w_feed_done_d = w_wait_live && arr_done;
    if (w_start_acc) begin
      w_timeout_err_d = 1'b0;
    end else if (w_hit_timeout) begin
      w_timeout_err_d = 1'b1;
    end else begin
      w_timeout_err_d = r_timeout_err;
    end
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_row0        <= '0;
      r_row1        <= '0;
      r_col0        <= '0;
      r_col1        <= '0;
      r_load        <= 1'b0;
      r_feed_done   <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_row0        <= w_row0_d;
      r_row1        <= w_row1_d;
      r_col0        <= w_col0_d;
      r_col1        <= w_col1_d;
      r_load        <= w_load_d;
      r_feed_done   <= w_feed_done_d;
      r_timeout_err <= w_timeout_err_d;
    end
  end

  assign ready       = (r_state == StIdle);
  assign row_in_row0 = r_row0;
  assign row_in_row1 = r_row1;
  assign col_in_col0 = r_col0;
  assign col_in_col1 = r_col1;
  assign load_in     = r_load;
  assign feed_done   = r_feed_done;
  assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_systolic_feeder_2x2.sv
// Directed bench for systolic_feeder_2x2 with hand-computed expected beats.
module tb_systolic_feeder_2x2;

  localparam int unsigned DW = 2;
  localparam int unsigned TIMEOUT = 15;

  logic          clk;
  logic          rst;
  logic          start;
  logic [4*DW-1:0] a_mat;
  logic [4*DW-1:0] b_mat;
  logic          arr_done;
  logic          ready;
  logic [DW-1:0] row_in_row0;
  logic [DW-1:0] row_in_row1;
  logic [DW-1:0] col_in_col0;
  logic [DW-1:0] col_in_col1;
  logic          load_in;
  logic          feed_done;
  logic          timeout_err;

  int n_chk;
  int n_err;

  systolic_feeder_2x2 #(
    .DW     (DW),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .a_mat      (a_mat),
    .b_mat      (b_mat),
    .arr_done   (arr_done),
    .ready      (ready),
    .row_in_row0(row_in_row0),
    .row_in_row1(row_in_row1),
    .col_in_col0(col_in_col0),
    .col_in_col1(col_in_col1),
    .load_in    (load_in),
    .feed_done  (feed_done),
    .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Packs {ld,row0,row1,col0,col1,ready,feed_done,timeout_err} for one comparison.
  task automatic expect_out(input string tag, input bit ld, input int r0, input int r1,
                            input int c0, input int c1, input bit rdy, input bit fd,
                            input bit to);
    logic [DW-1:0] e0, e1, e2, e3;
    logic [4*DW+3:0] exp_v, got_v;
    e0 = r0[DW-1:0];
    e1 = r1[DW-1:0];
    e2 = c0[DW-1:0];
    e3 = c1[DW-1:0];
    exp_v = {ld, e0, e1, e2, e3, rdy, fd, to};
    got_v = {load_in, row_in_row0, row_in_row1, col_in_col0, col_in_col1,
             ready, feed_done, timeout_err};
    check(tag, 32'(got_v), 32'(exp_v));
  endtask

  function automatic logic [4*DW-1:0] mat(input int m00, input int m01, input int m10,
                                          input int m11);
    logic [DW-1:0] x00, x01, x10, x11;
    x00 = m00[DW-1:0];
    x01 = m01[DW-1:0];
    x10 = m10[DW-1:0];
    x11 = m11[DW-1:0];
    return {x11, x10, x01, x00};
  endfunction

  task automatic launch(input logic [4*DW-1:0] a, input logic [4*DW-1:0] b);
    a_mat = a;
    b_mat = b;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    rst = 1'b0;
    start = 1'b1;
    arr_done = 1'b1;
    a_mat = '1;
    b_mat = '1;
    ticks(2);
    // Reset wins over start and arr_done.
    expect_out("reset_state", 0, 0, 0, 0, 0, 1, 0, 0);
    start = 1'b0;
    arr_done = 1'b0;
    rst = 1'b1;
    tick();
    expect_out("idle_after_reset", 0, 0, 0, 0, 0, 1, 0, 0);

    // Basic multiply: A=[1,2;3,0], B=[2,1;0,3].
    launch(mat(1, 2, 3, 0), mat(2, 1, 0, 3));
    expect_out("basic_beat0", 1, 1, 0, 2, 0, 0, 0, 0);
    tick();
    expect_out("basic_beat1", 1, 2, 3, 0, 1, 0, 0, 0);
    tick();
    expect_out("basic_beat2", 1, 0, 0, 0, 3, 0, 0, 0);
    tick();
    expect_out("basic_wait1", 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    arr_done = 1'b1;
    tick();
    arr_done = 1'b0;
    expect_out("basic_done_pulse", 0, 0, 0, 0, 0, 0, 1, 0);
    tick();
    expect_out("basic_ready", 0, 0, 0, 0, 0, 1, 0, 0);

    // Timeout: 15 WAIT cycles without arr_done.
    launch(mat(1, 1, 1, 1), mat(2, 2, 2, 2));
    ticks(3);
    ticks(TIMEOUT - 1);
    expect_out("to_last_wait", 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    expect_out("to_flush", 0, 0, 0, 0, 0, 0, 0, 1);
    tick();
    expect_out("to_idle_sticky", 0, 0, 0, 0, 0, 1, 0, 1);
    tick();
    expect_out("to_idle_hold", 0, 0, 0, 0, 0, 1, 0, 1);
    launch(mat(3, 0, 0, 0), mat(0, 0, 0, 1));
    expect_out("to_cleared_by_start", 1, 3, 0, 0, 0, 0, 0, 0);
    ticks(3);
    arr_done = 1'b1;
    tick();
    arr_done = 1'b0;
    expect_out("to_recover_done", 0, 0, 0, 0, 0, 0, 1, 0);
    tick();

    // Start held high; operands change mid-FEED.
    a_mat = mat(1, 2, 3, 1);
    b_mat = mat(3, 2, 1, 0);
    start = 1'b1;
    tick();
    expect_out("held_beat0", 1, 1, 0, 3, 0, 0, 0, 0);
    a_mat = mat(2, 1, 0, 3);
    b_mat = mat(1, 1, 1, 1);
    tick();
    expect_out("held_beat1", 1, 2, 3, 1, 2, 0, 0, 0);
    tick();
    expect_out("held_beat2", 1, 0, 1, 0, 0, 0, 0, 0);
    tick();
    arr_done = 1'b1;
    tick();
    arr_done = 1'b0;
    expect_out("held_done", 0, 0, 0, 0, 0, 0, 1, 0);
    tick();
    expect_out("held_ready", 0, 0, 0, 0, 0, 1, 0, 0);
    tick();
    start = 1'b0;
    expect_out("b2b_beat0", 1, 2, 0, 1, 0, 0, 0, 0);
    tick();
    expect_out("b2b_beat1", 1, 1, 0, 1, 1, 0, 0, 0);
    ticks(2);
    arr_done = 1'b1;
    tick();
    arr_done = 1'b0;
    tick();

    // Reset on FEED beat 1.
    launch(mat(3, 3, 3, 3), mat(3, 3, 3, 3));
    tick();
    expect_out("rst_pre_beat1", 1, 3, 3, 3, 3, 0, 0, 0);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    expect_out("rst_mid_feed", 0, 0, 0, 0, 0, 1, 0, 0);
    arr_done = 1'b1;
    tick();
    arr_done = 1'b0;
    expect_out("rst_late_arr_done", 0, 0, 0, 0, 0, 1, 0, 0);

    // Stray arr_done in IDLE and across FEED, then arr_done on the TIMEOUT cycle.
    arr_done = 1'b1;
    tick();
    expect_out("stray_idle", 0, 0, 0, 0, 0, 1, 0, 0);
    launch(mat(3, 3, 3, 3), mat(3, 3, 3, 3));
    expect_out("max_beat0", 1, 3, 0, 3, 0, 0, 0, 0);
    tick();
    expect_out("max_beat1", 1, 3, 3, 3, 3, 0, 0, 0);
    tick();
    expect_out("max_beat2", 1, 0, 3, 0, 3, 0, 0, 0);
    tick();
    arr_done = 1'b0;
    expect_out("max_wait_zeros", 0, 0, 0, 0, 0, 0, 0, 0);
    ticks(TIMEOUT - 1);
    arr_done = 1'b1;
    tick();
    arr_done = 1'b0;
    expect_out("tie_done_wins", 0, 0, 0, 0, 0, 0, 1, 0);
    tick();
    expect_out("tie_ready", 0, 0, 0, 0, 0, 1, 0, 0);
    tick();
    expect_out("tie_no_late_err", 0, 0, 0, 0, 0, 1, 0, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
